// File: rtl/move_input_controller.sv
// rtl/move_input_controller.sv - Connect-4 drop-button/column-switch front end with move handshake
module move_input_controller #(
  parameter int NUM_COLS        = 4,
  parameter int COL_W           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn,
  input  logic [NUM_COLS-1:0] sw,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_active,
  output logic                move_valid,
  output logic [COL_W-1:0]    move_col,
  input  logic                move_ready,
  output logic                err_pulse,
  output logic [1:0]          err_code,
  output logic [4:0]          move_count,
  output logic                busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, RELEASE} state_t;

  state_t                state, state_nx;
  logic                  btn_m, btn_s, btn_db, btn_db_d;
  logic [NUM_COLS-1:0]   sw_m, sw_s;
  logic [CNT_W-1:0]      db_cnt;
  logic                  press, one_hot, check_err, accept;
  logic [COL_W-1:0]      sel;
  logic [1:0]            code_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_m    <= 1'b0;
      btn_s    <= 1'b0;
      sw_m     <= '0;
      sw_s     <= '0;
      btn_db   <= 1'b0;
      btn_db_d <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_m    <= btn;
      btn_s    <= btn_m;
      sw_m     <= sw;
      sw_s     <= sw_m;
      btn_db_d <= btn_db;
      // btn_db only follows btn_s after it has disagreed for DEBOUNCE_CYCLES straight clocks
      if (btn_s != btn_db) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db <= btn_s;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign press = btn_db & ~btn_db_d;

  always_comb begin
    sel     = '0;
    one_hot = $onehot(sw_s);
    for (int i = 0; i < NUM_COLS; i++) begin
      if (sw_s[i]) sel = COL_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    check_err = 1'b0;
    code_nx   = err_code;
    accept    = 1'b0;
    case (state)
      IDLE: if (press) state_nx = CHECK;
      CHECK: begin
        state_nx  = RELEASE;
        check_err = 1'b1;
        if (!game_active)       code_nx = 2'b11;
        else if (!one_hot)      code_nx = 2'b01;
        else if (col_full[sel]) code_nx = 2'b10;
        else begin
          code_nx   = 2'b00;
          check_err = 1'b0;
          state_nx  = ISSUE;
        end
      end
      ISSUE: begin
        if (move_ready) begin
          accept   = 1'b1;
          state_nx = RELEASE;
        end else if (!game_active) begin
          state_nx = RELEASE;
        end
      end
      RELEASE: if (!btn_db) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      move_col   <= '0;
      err_pulse  <= 1'b0;
      err_code   <= 2'b00;
      move_count <= 5'd0;
    end else begin
      err_pulse <= check_err;
      err_code  <= code_nx;
      if (state == CHECK && state_nx == ISSUE) move_col <= sel;
      if (accept && move_count != 5'd31) move_count <= move_count + 5'd1;
    end
  end

  assign move_valid = (state == ISSUE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_move_input_controller.sv
// tb/tb_move_input_controller.sv - randomized self-checking bench for move_input_controller
module tb_move_input_controller;

  localparam int NC = 4;
  localparam int CW = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset, btn, game_active, move_ready;
  logic [NC-1:0] sw, col_full;
  logic          move_valid, err_pulse, busy;
  logic [CW-1:0] move_col;
  logic [1:0]    err_code;
  logic [4:0]    move_count;

  int n_cmp = 0;
  int n_bad = 0;
  int model_count = 0;

  always #5 clk = ~clk;

  move_input_controller #(.NUM_COLS(NC), .COL_W(CW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .btn(btn), .sw(sw), .col_full(col_full),
    .game_active(game_active), .move_valid(move_valid), .move_col(move_col),
    .move_ready(move_ready), .err_pulse(err_pulse), .err_code(err_code),
    .move_count(move_count), .busy(busy)
  );

  function automatic int model_col(input logic [3:0] s);
    model_col = 0;
    for (int i = 0; i < 4; i++) if (s == (4'b0001 << i)) model_col = i;
  endfunction

  function automatic logic [1:0] model_code(input logic [3:0] s, input logic [3:0] f, input logic a);
    if (!a) return 2'b11;
    if ($countones(s) != 1) return 2'b01;
    if (f[model_col(s)]) return 2'b10;
    return 2'b00;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; btn = 1'b0; move_ready = 1'b0;
    tick(2);
    reset = 1'b1;
    model_count = 0;
  endtask

  task automatic wait_valid(input int budget, output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      if (lat < 0) begin
        @(negedge clk);
        if (move_valid) lat = c;
      end
    end
  endtask

  // holds btn for 'hold' clocks, watches 40 clocks, reports first event (1 move, 2 error)
  task automatic run_press(input int hold, output int kind, output int lat, output logic [1:0] code,
                           output logic [1:0] col, output int n_valid, output int n_err);
    kind = 0; lat = -1; col = 0; n_valid = 0; n_err = 0;
    btn = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == hold) btn = 1'b0;
      if (move_valid) begin
        n_valid++;
        if (kind == 0) begin kind = 1; lat = c; col = move_col; end
      end
      if (err_pulse) begin
        n_err++;
        if (kind == 0) begin kind = 2; lat = c; end
      end
    end
    btn = 1'b0;
    code = err_code;
  endtask

  task automatic test_reset();
    btn = 1'b1; sw = 4'b1111; game_active = 1'b1; move_ready = 1'b1; reset = 1'b0;
    tick(2);
    n_cmp++;
    if ({move_valid, move_col, err_pulse, err_code, move_count, busy} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0", {move_valid, move_col, err_pulse, err_code, move_count, busy});
    end
    reset = 1'b1; btn = 1'b0; model_count = 0;
    tick(10);
  endtask

  task automatic test_legal_move();
    int kind, lat, nv, ne;
    logic [1:0] code, col;
    do_reset();
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b0100; move_ready = 1'b1;
    tick(3);
    run_press(10, kind, lat, code, col, nv, ne);
    model_count++;
    n_cmp++; if (kind !== 1) begin n_bad++; $display("FAIL legal_kind: got %0d expected 1", kind); end
    n_cmp++; if (lat !== DB + 4) begin n_bad++; $display("FAIL legal_latency: got %0d expected %0d", lat, DB + 4); end
    n_cmp++; if (col !== 2'd2) begin n_bad++; $display("FAIL legal_col: got %0d expected 2", col); end
    n_cmp++; if (nv !== 1) begin n_bad++; $display("FAIL legal_valid_width: got %0d expected 1", nv); end
    n_cmp++; if (ne !== 0) begin n_bad++; $display("FAIL legal_err_pulses: got %0d expected 0", ne); end
    n_cmp++; if (move_count !== 5'(model_count)) begin n_bad++; $display("FAIL legal_count: got %0d expected %0d", move_count, model_count); end
  endtask

  task automatic test_bounce();
    int hits = 0;
    for (int c = 0; c < 30; c++) begin
      btn = (c < 20) ? (((c / 2) % 2) == 0) : 1'b0;
      @(negedge clk);
      if (move_valid || err_pulse || busy) hits++;
    end
    n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL bounce_activity: got %0d active clocks expected 0", hits); end
  endtask

  task automatic test_error_priority();
    logic [3:0] sws [3] = '{4'b0000, 4'b0010, 4'b0011};
    logic [3:0] fls [3] = '{4'b0000, 4'b0010, 4'b0000};
    logic       act [3] = '{1'b1, 1'b1, 1'b0};
    logic [1:0] exp [3] = '{2'b01, 2'b10, 2'b11};
    int kind, lat, nv, ne;
    logic [1:0] code, col;
    move_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sw = sws[i]; col_full = fls[i]; game_active = act[i];
      tick(3);
      run_press(10, kind, lat, code, col, nv, ne);
      n_cmp++; if (kind !== 2 || ne !== 1 || nv !== 0)
        begin n_bad++; $display("FAIL err%0d_event: got kind %0d err %0d valid %0d expected 2/1/0", i, kind, ne, nv); end
      n_cmp++; if (code !== exp[i]) begin n_bad++; $display("FAIL err%0d_code: got %b expected %b", i, code, exp[i]); end
      n_cmp++; if (lat !== DB + 4) begin n_bad++; $display("FAIL err%0d_latency: got %0d expected %0d", i, lat, DB + 4); end
    end
    n_cmp++; if (move_count !== 5'(model_count)) begin n_bad++; $display("FAIL err_count: got %0d expected %0d", move_count, model_count); end
    game_active = 1'b1; col_full = 4'b0000;
  endtask

  task automatic test_stall();
    int lat, bad = 0;
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b1000; move_ready = 1'b0;
    tick(3);
    btn = 1'b1;
    wait_valid(20, lat);
    n_cmp++; if (lat < 0) begin n_bad++; $display("FAIL stall_timeout: got no move_valid expected one within 20"); end
    for (int k = 1; k <= 6; k++) begin
      if (move_valid !== 1'b1 || move_col !== 2'd3) bad++;
      if (k == 2) sw = 4'b0001;
      if (k == 6) move_ready = 1'b1;
      @(negedge clk);
    end
    model_count++;
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad clocks expected 0", bad); end
    n_cmp++; if (move_valid !== 1'b0) begin n_bad++; $display("FAIL stall_accept: got valid %b expected 0", move_valid); end
    n_cmp++; if (move_count !== 5'(model_count)) begin n_bad++; $display("FAIL stall_count: got %0d expected %0d", move_count, model_count); end
    btn = 1'b0;
    tick(15);
  endtask

  task automatic test_one_per_press();
    int lat, extra = 0, idle = 0, idle_lat = -1, kind, nv, ne;
    logic [1:0] code, col;
    do_reset();
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b0001; move_ready = 1'b1;
    tick(3);
    btn = 1'b1;
    wait_valid(20, lat);
    model_count++;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (move_valid) extra++;
      if (!busy) idle++;
    end
    n_cmp++; if (lat < 0 || extra !== 0) begin n_bad++; $display("FAIL hold_single_move: got lat %0d extra %0d expected one move", lat, extra); end
    n_cmp++; if (idle !== 0) begin n_bad++; $display("FAIL hold_busy: got %0d idle clocks expected 0", idle); end
    btn = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!busy && idle_lat < 0) idle_lat = c;
    end
    n_cmp++; if (idle_lat !== DB + 3) begin n_bad++; $display("FAIL release_latency: got %0d expected %0d", idle_lat, DB + 3); end
    run_press(10, kind, lat, code, col, nv, ne);
    model_count++;
    n_cmp++; if (kind !== 1 || move_count !== 5'd2) begin n_bad++; $display("FAIL second_press: got kind %0d count %0d expected 1/2", kind, move_count); end
  endtask

  task automatic test_abort();
    int lat;
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b0010; move_ready = 1'b0;
    tick(3);
    btn = 1'b1;
    wait_valid(20, lat);
    game_active = 1'b0;
    @(negedge clk);
    n_cmp++; if (lat < 0 || move_valid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got lat %0d valid %b expected drop", lat, move_valid); end
    n_cmp++; if (err_pulse !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL abort_state: got err %b busy %b expected 0/1", err_pulse, busy); end
    n_cmp++; if (move_count !== 5'(model_count)) begin n_bad++; $display("FAIL abort_count: got %0d expected %0d", move_count, model_count); end
    btn = 1'b0; game_active = 1'b1;
    tick(15);
  endtask

  task automatic test_reset_mid();
    int lat;
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b0100; move_ready = 1'b0;
    tick(3);
    btn = 1'b1;
    wait_valid(20, lat);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lat < 0 || {move_valid, move_col, err_pulse, err_code, move_count, busy} !== 12'd0) begin
      n_bad++;
      $display("FAIL reset_mid: got lat %0d outputs %b expected 0", lat, {move_valid, move_col, err_pulse, err_code, move_count, busy});
    end
    reset = 1'b1; btn = 1'b0; model_count = 0;
    tick(10);
  endtask

  task automatic test_random();
    int kind, lat, nv, ne;
    logic [1:0] code, col, exp;
    move_ready = 1'b1;
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 1) != 0) sw = 4'b0001 << $urandom_range(0, 3);
      else                           sw = 4'($urandom_range(0, 15));
      col_full = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      game_active = ($urandom_range(0, 4) != 0);
      exp = model_code(sw, col_full, game_active);
      tick(3);
      run_press($urandom_range(7, 12), kind, lat, code, col, nv, ne);
      if (exp == 2'b00) begin
        if (model_count < 31) model_count++;
        n_cmp++; if (kind !== 1 || nv !== 1 || col !== 2'(model_col(sw)))
          begin n_bad++; $display("FAIL rand%0d_move: got kind %0d valid %0d col %0d expected 1/1/%0d", it, kind, nv, col, model_col(sw)); end
      end else begin
        n_cmp++; if (kind !== 2 || nv !== 0 || ne !== 1)
          begin n_bad++; $display("FAIL rand%0d_error: got kind %0d valid %0d err %0d expected 2/0/1", it, kind, nv, ne); end
      end
      n_cmp++; if (code !== exp) begin n_bad++; $display("FAIL rand%0d_code: got %b expected %b", it, code, exp); end
      n_cmp++; if (move_count !== 5'(model_count)) begin n_bad++; $display("FAIL rand%0d_count: got %0d expected %0d", it, move_count, model_count); end
    end
    game_active = 1'b1; col_full = 4'b0000;
  endtask

  task automatic test_saturation();
    int kind, lat, nv, ne;
    logic [1:0] code, col;
    game_active = 1'b1; col_full = 4'b0000; sw = 4'b0001; move_ready = 1'b1;
    tick(3);
    while (model_count < 33) begin
      run_press(10, kind, lat, code, col, nv, ne);
      model_count++;
    end
    n_cmp++; if (move_count !== 5'd31) begin n_bad++; $display("FAIL saturation: got %0d expected 31", move_count); end
    model_count = 31;
  endtask

  initial begin
    reset = 1'b0; btn = 1'b0; sw = '0; col_full = '0; game_active = 1'b1; move_ready = 1'b0;
    test_reset();
    test_legal_move();
    test_bounce();
    test_error_priority();
    test_stall();
    test_one_per_press();
    test_abort();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/move_input_controller.md
# move_input_controller

Front-end input block for the Connect-4 game: the input-side counterpart of the board-to-pin output path. It synchronizes and debounces the player's drop button and the four column switches, and validates the requested column against the game state. Legal moves are handed to the game core over a valid/ready handshake; illegal requests are reported with an error code.

## Interface
Parameters:
- NUM_COLS, 4, number of board columns; one switch per column
- COL_W, 2, width of the column index; must equal clog2(NUM_COLS)
- DEBOUNCE_CYCLES, 50000, consecutive stable clocks required before the debounced button changes; must be ≥ 2

Ports:
- clk  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-low reset
- btn  input  1  raw drop button (BTN_EAST), asynchronous, bouncy
- sw  input  NUM_COLS  raw column switches (Switch_3..Switch_0), asynchronous; exactly one high selects a column
- col_full  input  NUM_COLS  from game core; bit i high means column i cannot accept a piece
- game_active  input  1  from game core FSM; high while a game is in progress
- move_valid  output  1  move offered to game core
- move_col  output  COL_W  column index of the offered move; stable while move_valid is high
- move_ready  input  1  game core accepts the move when high together with move_valid
- err_pulse  output  1  one-clock pulse on a rejected request
- err_code  output  2  00 none, 01 switch pattern not one-hot, 10 column full, 11 game inactive; holds until the next request is evaluated
- move_count  output  5  accepted moves since reset; saturates at 31
- busy  output  1  high in any state other than IDLE

## Operation
- Input synchronization: btn and sw each pass through a 2-flop synchronizer, giving btn_s and sw_s.
- Debounce:
  - A counter increments each clock while btn_s differs from btn_db. It clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 and btn_s still differs, btn_db takes btn_s and the counter clears.
  - A press is btn_db rising (btn_db high, its 1-clock-delayed copy low).
- FSM states and transitions:
  - IDLE: a press moves to CHECK. Presses are ignored in every other state.
  - CHECK: evaluates sw_s, col_full and game_active for one clock, using this priority:
    - game_active low: err_code=11, err_pulse, go to RELEASE.
    - Else sw_s not one-hot (zero or multiple bits set): err_code=01, err_pulse, go to RELEASE.
    - Else col_full at the selected index is set: err_code=10, err_pulse, go to RELEASE.
    - Else: latch the one-hot-to-binary index into move_col, set err_code=00, go to ISSUE.
  - ISSUE: move_valid high. move_col holds its value for the whole state.
    - move_ready high: handshake completes, move_count increments (saturating), go to RELEASE.
    - game_active falls before acceptance: move_valid drops on the next clock, go to RELEASE. No error is raised and the count does not change.
  - RELEASE: waits for btn_db low, then returns to IDLE. This guarantees one move per press.
- Switch changes after CHECK have no effect on move_col.
- move_col is the binary index of the single set bit of sw_s (bit 0 → 0, bit 3 → 3).

## Timing
- Reset (reset low at a clock edge) clears:
  - outputs: move_valid, move_col, err_pulse, err_code, move_count, busy all 0
  - internal state: synchronizers, btn_db, debounce counter, edge register; FSM goes to IDLE
- Reset has priority in every state. Asserting it during ISSUE drops move_valid on the next edge without counting the move.
- Raw btn to btn_s: 2 clocks. btn_s change to btn_db change: DEBOUNCE_CYCLES clocks if stable.
- btn_db rise to CHECK: 1 clock. CHECK to ISSUE (move_valid high) or err_pulse: 1 clock.
- Total raw press to move_valid: DEBOUNCE_CYCLES+4 clocks.
- err_pulse is asserted in the clock after CHECK, exactly one clock wide.
- If move_ready is already high on the first ISSUE clock, the handshake completes that clock. move_valid is high for exactly 1 clock.
- move_count updates on the clock the handshake completes and is visible the next clock.
- A bounce shorter than DEBOUNCE_CYCLES clocks never changes btn_db.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Legal move: reset; game_active=1; col_full=0000; sw=0100; hold btn high for 10 clocks. Required: move_valid rises 8 clocks after btn rises, move_col=2, move_ready=1 → move_count=1, move_valid high for exactly 1 clock.
- Bounce rejection: toggle btn every 2 clocks for 20 clocks, then hold it low. Required: no move_valid, no err_pulse, busy stays 0.
- Error priority: run three presses.
  - sw=0000: err_pulse with err_code=01.
  - sw=0010 with col_full=0010: err_code=10.
  - sw=0011 with game_active=0: err_code=11.
  - move_count unchanged throughout.
- Handshake stall and hold: legal press with move_ready low for 5 clocks. Change sw during the stall. Required: move_valid held and move_col unchanged for all 5 clocks; acceptance on the 6th clock; one count.
- One move per press: hold btn high for 30 clocks after acceptance. Required: a single move; FSM stays in RELEASE (busy=1) until btn_db falls; a second press then yields a second move, count=2.
- Abort and reset mid-operation:
  - Drop game_active during ISSUE: move_valid falls the next clock, no error, count unchanged.
  - Repeat the press and pull reset low in ISSUE: all outputs are 0 on the next clock.
